// File: rtl/hex_display_sched.sv
// hex_display_sched: two-requester write arbiter, 8-entry digit store and a
// prescaled scan that refreshes one registered 7-segment output per tick
// through a single shared decoder.
module hex_display_sched #(
   parameter int TICK_DIV = 50000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       req_a,
   input  logic [2:0] wr_a_digit,
   input  logic [3:0] wr_a_data,
   input  logic       wr_a_blank,
   output logic       gnt_a,
   input  logic       req_b,
   input  logic [2:0] wr_b_digit,
   input  logic [3:0] wr_b_data,
   input  logic       wr_b_blank,
   output logic       gnt_b,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [6:0] HEX6,
   output logic [6:0] HEX7,
   output logic [2:0] scan_digit
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   typedef enum logic {PRI_A, PRI_B} pri_t;

   pri_t          pri_q, pri_d;
   logic          grant_a, grant_b;
   logic          elig_a, elig_b;
   logic [4:0]    entry [8];
   logic [6:0]    hex_q [8];
   logic [CW-1:0] cnt;
   logic          tick;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one stored entry
   function automatic logic [6:0] seg_decode(input logic [4:0] e);
      logic [6:0] s;
      s = 7'h7F;
      if (!e[4]) begin
         case (e[3:0])
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
         endcase
      end
      return s;
   endfunction

   // Arbitration: a requester is not eligible in its own grant cycle
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      pri_d   = pri_q;
      elig_a  = req_a && !gnt_a;
      elig_b  = req_b && !gnt_b;
      if (elig_a && (!elig_b || pri_q == PRI_A)) begin
         grant_a = 1'b1;
         pri_d   = PRI_B;
      end else if (elig_b) begin
         grant_b = 1'b1;
         pri_d   = PRI_A;
      end
   end

   // Priority state and registered one-cycle grants
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         pri_q <= PRI_A;
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
      end else begin
         pri_q <= pri_d;
         gnt_a <= grant_a;
         gnt_b <= grant_b;
      end
   end

   // Digit store: written at the granting edge
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         for (int unsigned i = 0; i < 8; i++) entry[i] <= 5'h10;
      end else if (grant_a) begin
         entry[wr_a_digit] <= {wr_a_blank, wr_a_data};
      end else if (grant_b) begin
         entry[wr_b_digit] <= {wr_b_blank, wr_b_data};
      end
   end

   assign tick = (cnt == CNT_MAX);

   // Refresh prescaler, wraps at TICK_DIV-1
   always_ff @(posedge CLOCK_50) begin
      if (RESET || tick) cnt <= '0;
      else               cnt <= cnt + 1'b1;
   end

   // Scan: decode the pre-edge entry, so a same-edge write shows next visit
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         scan_digit <= '0;
         for (int unsigned i = 0; i < 8; i++) hex_q[i] <= 7'h7F;
      end else if (tick) begin
         hex_q[scan_digit] <= seg_decode(entry[scan_digit]);
         scan_digit        <= scan_digit + 1'b1;
      end
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];
   assign HEX6 = hex_q[6];
   assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_display_sched.sv
// Directed bench for hex_display_sched with a write scoreboard and a
// per-digit expected-entry table, TICK_DIV = 4.
module tb_hex_display_sched;

   logic       clk;
   logic       rst;
   logic       req_a, req_b;
   logic [2:0] wr_a_digit, wr_b_digit;
   logic [3:0] wr_a_data, wr_b_data;
   logic       wr_a_blank, wr_b_blank;
   logic       gnt_a, gnt_b;
   logic [6:0] hex [8];
   logic [2:0] scan_digit;

   typedef struct {
      bit         who_b;
      int         rel;
      logic [2:0] dig;
      logic [3:0] dat;
      logic       blk;
   } wr_t;

   localparam logic [6:0] SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam logic [55:0] ALL_DARK = {8{7'h7F}};

   wr_t        sbq [$];
   logic [4:0] exp_ent [8];
   int         pend_a, pend_b;
   int         k;
   int         n_checks, n_errors;

   hex_display_sched #(.TICK_DIV(4)) dut (
      .CLOCK_50(clk), .RESET(rst),
      .req_a(req_a), .wr_a_digit(wr_a_digit), .wr_a_data(wr_a_data),
      .wr_a_blank(wr_a_blank), .gnt_a(gnt_a),
      .req_b(req_b), .wr_b_digit(wr_b_digit), .wr_b_data(wr_b_data),
      .wr_b_blank(wr_b_blank), .gnt_b(gnt_b),
      .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]), .HEX3(hex[3]),
      .HEX4(hex[4]), .HEX5(hex[5]), .HEX6(hex[6]), .HEX7(hex[7]),
      .scan_digit(scan_digit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [4:0] e);
      return e[4] ? 7'h7F : SEG[e[3:0]];
   endfunction

   function automatic logic [55:0] hex_all();
      return {hex[7], hex[6], hex[5], hex[4], hex[3], hex[2], hex[1], hex[0]};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) begin
         cyc();
         check("rst_gnt", 64'({gnt_a, gnt_b}), 64'd0);
         check("rst_hex", 64'(hex_all()), 64'(ALL_DARK));
         check("rst_scan", 64'(scan_digit), 64'd0);
      end
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 8; i++) exp_ent[i] = 5'h10;
   endtask

   task automatic push_wr(input bit b, input int rel, input logic [2:0] d,
                          input logic [3:0] v, input logic bl);
      wr_t e;
      e.who_b = b;
      e.rel   = rel;
      e.dig   = d;
      e.dat   = v;
      e.blk   = bl;
      sbq.push_back(e);
      if (b) begin
         wr_b_digit = d; wr_b_data = v; wr_b_blank = bl; req_b = 1'b1; pend_b++;
      end else begin
         wr_a_digit = d; wr_a_data = v; wr_a_blank = bl; req_a = 1'b1; pend_a++;
      end
   endtask

   // Pop one scoreboard entry per observed grant; drop req once drained
   task automatic wait_grants();
      int  rel;
      wr_t e;
      rel = 0;
      while (sbq.size() > 0 && rel < 20) begin
         cyc();
         rel++;
         check("gnt_excl", 64'(gnt_a & gnt_b), 64'd0);
         if (gnt_a || gnt_b) begin
            e = sbq.pop_front();
            check("gnt_who", 64'(gnt_b), 64'(e.who_b));
            check("gnt_cycle", 64'(rel), 64'(e.rel));
            exp_ent[e.dig] = {e.blk, e.dat};
            if (e.who_b) begin
               pend_b--;
               if (pend_b == 0) req_b = 1'b0;
            end else begin
               pend_a--;
               if (pend_a == 0) req_a = 1'b0;
            end
         end
      end
      if (sbq.size() > 0) begin
         check("gnt_timeout", 64'(sbq.size()), 64'd0);
         sbq.delete();
         pend_a = 0; pend_b = 0;
         req_a = 1'b0; req_b = 1'b0;
      end
   endtask

   task automatic check_display(input string tag);
      repeat (33) cyc();
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_hex%0d", tag, i), 64'(hex[i]), 64'(exp_seg(exp_ent[i])));
   endtask

   initial begin
      n_checks = 0; n_errors = 0; pend_a = 0; pend_b = 0; k = 0;
      rst = 1'b1;
      req_a = 1'b0; wr_a_digit = '0; wr_a_data = '0; wr_a_blank = 1'b0;
      req_b = 1'b0; wr_b_digit = '0; wr_b_data = '0; wr_b_blank = 1'b0;

      // Reset then idle: dark display, no grants, scan advancing every 4 cycles
      do_reset(2);
      repeat (40) begin
         cyc();
         check("idle_scan", 64'(scan_digit), 64'((k / 4) % 8));
         check("idle_gnt", 64'({gnt_a, gnt_b}), 64'd0);
         check("idle_hex", 64'(hex_all()), 64'(ALL_DARK));
      end

      // Single write from A
      push_wr(1'b0, 1, 3'd3, 4'hB, 1'b0);
      wait_grants();
      check_display("single");

      // Contention from reset release: A, B, A, B on consecutive cycles
      push_wr(1'b0, 1, 3'd0, 4'h8, 1'b0);
      push_wr(1'b1, 2, 3'd1, 4'h1, 1'b0);
      push_wr(1'b0, 3, 3'd0, 4'h8, 1'b0);
      push_wr(1'b1, 4, 3'd1, 4'h1, 1'b0);
      do_reset(2);
      wait_grants();
      check_display("contend");

      // Collision: write digit 0 at the edge (36) that refreshes digit 0
      do_reset(1);
      push_wr(1'b0, 1, 3'd0, 4'h3, 1'b0);
      wait_grants();
      while (k < 35) cyc();
      push_wr(1'b0, 1, 3'd0, 4'h5, 1'b0);
      wait_grants();
      check("coll_old", 64'(hex[0]), 64'h30);
      check("coll_scan", 64'(scan_digit), 64'd1);
      while (k < 67) cyc();
      check("coll_hold", 64'(hex[0]), 64'h30);
      cyc();
      check("coll_new", 64'(hex[0]), 64'h12);

      // Decode sweep, alternating requesters, then blank digit 2
      for (int v = 0; v < 16; v++) begin
         push_wr(v[0], 1, 3'(v), 4'(v), 1'b0);
         wait_grants();
         if (v == 7) check_display("sweep_lo");
      end
      check_display("sweep_hi");
      push_wr(1'b1, 1, 3'd2, 4'h4, 1'b1);
      wait_grants();
      check_display("blank");

      // Mid-op reset with req_b pending: dropped, then re-granted after release
      wr_b_digit = 3'd5; wr_b_data = 4'h7; wr_b_blank = 1'b0; req_b = 1'b1;
      do_reset(1);
      push_wr(1'b1, 1, 3'd5, 4'h7, 1'b0);
      wait_grants();
      push_wr(1'b0, 1, 3'd6, 4'hE, 1'b0);
      wait_grants();
      // Priority now rests with B; reset must return it to A
      push_wr(1'b0, 1, 3'd4, 4'hC, 1'b0);
      push_wr(1'b1, 2, 3'd7, 4'hD, 1'b0);
      do_reset(1);
      wait_grants();
      check_display("midop");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
